// File: rtl/epc_crc_init.sv
// Power-up Gen2 CRC-16 engine: fetches PC + EPC words from the EPC bank and
// folds them bit-serially into the seed handed to the RNG on init_done.
module epc_crc_init #(
  parameter int          MAX_WORDS   = 31,
  parameter int          ACK_TIMEOUT = 64,
  parameter logic [15:0] PRESET      = 16'hFFFF,
  parameter logic [15:0] POLY        = 16'h1021
) (
  input  logic        DOUB_BLF,
  input  logic        rst_n,
  input  logic        por_done,
  output logic        mem_rd_en,
  output logic [5:0]  mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ack,
  output logic [15:0] crc_calc,
  output logic        init_done,
  output logic        crc_err,
  output logic        busy
);

  localparam int         TW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [5:0] MAXW = 6'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, READ, CALC, DONE, ABORT} state_t;

  state_t        state, state_nxt;
  logic [15:0]   crc, crc_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [5:0]    word_cnt, word_cnt_nxt;
  logic [5:0]    word_tot, word_tot_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          rd_nxt, done_nxt, err_nxt;
  logic [5:0]    addr_nxt;
  logic [15:0]   calc_nxt;
  logic [15:0]   crc_step;
  logic [5:0]    word_inc;
  logic [5:0]    pc_len;

  // One MSB-first bit of the Gen2 CRC-16.
  assign crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ shreg[15]) ? POLY : 16'h0000);
  assign word_inc = word_cnt + 6'd1;
  assign pc_len   = ({1'b0, mem_data[15:11]} > MAXW) ? MAXW : {1'b0, mem_data[15:11]};
  assign busy     = (state != IDLE);

  always_ff @(posedge DOUB_BLF or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= PRESET;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      word_tot  <= '0;
      tmo       <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      crc_calc  <= '0;
      init_done <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      crc       <= crc_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      word_cnt  <= word_cnt_nxt;
      word_tot  <= word_tot_nxt;
      tmo       <= tmo_nxt;
      mem_rd_en <= rd_nxt;
      mem_addr  <= addr_nxt;
      crc_calc  <= calc_nxt;
      init_done <= done_nxt;
      crc_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    crc_nxt      = crc;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    word_cnt_nxt = word_cnt;
    word_tot_nxt = word_tot;
    tmo_nxt      = tmo;
    rd_nxt       = mem_rd_en;
    addr_nxt     = mem_addr;
    calc_nxt     = crc_calc;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: if (por_done) begin
        state_nxt    = READ;
        addr_nxt     = 6'd1;
        word_cnt_nxt = '0;
        crc_nxt      = PRESET;
        rd_nxt       = 1'b1;
        tmo_nxt      = '0;
      end
      READ: begin
        if (mem_ack) begin
          shreg_nxt   = mem_data;
          rd_nxt      = 1'b0;
          bit_cnt_nxt = 4'd15;
          state_nxt   = CALC;
          // The PC word carries the EPC length in its top five bits.
          if (word_cnt == 6'd0) word_tot_nxt = 6'd1 + pc_len;
        end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
          state_nxt = ABORT;
          rd_nxt    = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo + TW'(1);
        end
      end
      CALC: begin
        crc_nxt     = crc_step;
        shreg_nxt   = {shreg[14:0], 1'b0};
        bit_cnt_nxt = bit_cnt - 4'd1;
        if (bit_cnt == 4'd0) begin
          word_cnt_nxt = word_inc;
          if (word_inc == word_tot) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            calc_nxt  = ~crc_step;
          end else begin
            state_nxt = READ;
            addr_nxt  = mem_addr + 6'd1;
            rd_nxt    = 1'b1;
            tmo_nxt   = '0;
          end
        end
      end
      DONE:  state_nxt = IDLE;
      ABORT: begin
        state_nxt = IDLE;
        rd_nxt    = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_epc_crc_init.sv
// Randomized bench for epc_crc_init: latency-randomized memory responder plus
// a word-list CRC reference model.
module tb_epc_crc_init;
  localparam int MAXW = 8;
  localparam int TMO  = 64;

  logic        clk = 1'b0, rst_n = 1'b1, por_done = 1'b0;
  logic        mem_rd_en, mem_ack = 1'b0, init_done, crc_err, busy;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data = '0, crc_calc;

  epc_crc_init #(.MAX_WORDS(MAXW), .ACK_TIMEOUT(TMO)) dut (
    .DOUB_BLF(clk), .rst_n(rst_n), .por_done(por_done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .crc_calc(crc_calc), .init_done(init_done), .crc_err(crc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder
  logic [15:0] mem [0:63];
  int  max_dly = 0, cur_dly = 0, wait_cnt = 0, rd_idx = 0, withhold = -1, hold_cycles = 0;
  int  stab_err = 0;
  bit  spur = 1'b0, in_req = 1'b0;
  logic [5:0] req_addr;
  int  addrs [$];

  initial forever begin
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = 16'($urandom);
    if (!rst_n) in_req = 1'b0;
    else if (mem_rd_en) begin
      if (!in_req) begin
        in_req = 1'b1; req_addr = mem_addr; wait_cnt = 0;
        cur_dly = $urandom_range(max_dly, 0);
      end else if (mem_addr !== req_addr) stab_err++;
      if (rd_idx == withhold) hold_cycles++;
      else if (wait_cnt >= cur_dly) begin
        mem_ack = 1'b1; mem_data = mem[mem_addr];
        addrs.push_back(int'(mem_addr)); rd_idx++; in_req = 1'b0;
      end else wait_cnt++;
    end else begin
      in_req = 1'b0;
      // Stray acks outside a read must be ignored.
      if (spur && $urandom_range(3, 0) == 0) mem_ack = 1'b1;
    end
  end

  // Pulse monitor
  int n_done = 0, n_err = 0, done_cyc = 0;
  logic [15:0] done_crcs [$];
  initial forever begin
    @(negedge clk);
    if (init_done) begin n_done++; done_cyc = cyc; done_crcs.push_back(crc_calc); end
    if (crc_err) n_err++;
  end

  // Reference model: words 1..n of the bank, CRC-16 preset FFFF, result inverted.
  function automatic int nwords(input logic [15:0] pc);
    int l = int'(pc[15:11]);
    if (l > MAXW) l = MAXW;
    return 1 + l;
  endfunction

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int w = 1; w <= n; w++)
      for (int b = 15; b >= 0; b--) begin
        logic fb = c[15] ^ mem[w][b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return ~c;
  endfunction

  task automatic fill(input logic [15:0] pc);
    mem[0] = 16'($urandom);
    mem[1] = pc;
    for (int i = 2; i < 64; i++) mem[i] = 16'($urandom);
  endtask

  task automatic clear_logs();
    addrs.delete(); done_crcs.delete();
    rd_idx = 0; stab_err = 0; n_done = 0; n_err = 0; hold_cycles = 0;
  endtask

  task automatic start(output int s);
    @(negedge clk); por_done = 1'b1;
    @(posedge clk); #1; s = cyc;
  endtask

  task automatic run_case(input string tag, input logic [15:0] pc, input int dly, input bit tog);
    int n, s;
    logic [15:0] exp;
    fill(pc); max_dly = dly; clear_logs();
    n = nwords(pc); exp = ref_crc(n);
    start(s);
    for (int i = 0; i < 3000 && n_done == 0 && n_err == 0; i++) begin
      @(negedge clk);
      if (tog) por_done = 1'($urandom_range(1, 0));
      else por_done = 1'b0;
      #1;
    end
    por_done = 1'b0;
    chk({tag, "_finished"}, n_done, 1);
    if (dly == 0) chk({tag, "_latency"}, done_cyc - s, 17 * n);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_one_done"}, n_done, 1);
    chk({tag, "_no_err"}, n_err, 0);
    chk({tag, "_crc"}, crc_calc, exp);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_nreads"}, addrs.size(), n);
    for (int i = 0; i < addrs.size() && i < n; i++) chk({tag, "_addr"}, addrs[i], i + 1);
    chk({tag, "_addr_stable"}, stab_err, 0);
  endtask

  task automatic abort_case();
    int s;
    logic [15:0] prev;
    fill({5'd6, 11'($urandom)}); max_dly = 2; clear_logs();
    withhold = 2; prev = crc_calc;
    start(s);
    for (int i = 0; i < 1000 && n_err == 0; i++) begin
      @(negedge clk); por_done = 1'b0; #1;
    end
    chk("abort_err", n_err, 1);
    chk("abort_rd_low", mem_rd_en, 0);
    @(negedge clk); #1;
    chk("abort_idle", busy, 0);
    chk("abort_err_pulse", crc_err, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_one_err", n_err, 1);
    chk("abort_wait", hold_cycles, TMO);
    chk("abort_no_done", n_done, 0);
    chk("abort_crc_kept", crc_calc, prev);
    chk("abort_nreads", addrs.size(), 2);
    withhold = -1;
  endtask

  task automatic reset_case();
    int s;
    fill({5'd6, 11'($urandom)}); max_dly = 0; clear_logs();
    start(s);
    for (int i = 0; i < 200 && rd_idx < 2; i++) begin
      @(negedge clk); por_done = 1'b0;
    end
    chk("rst_reached_w2", rd_idx, 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_crc", crc_calc, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_no_pulses", n_done + n_err, 0);
  endtask

  task automatic b2b_case();
    int s, n;
    logic [15:0] exp;
    fill({5'd2, 11'($urandom)}); max_dly = 3; clear_logs();
    n = nwords(mem[1]); exp = ref_crc(n);
    start(s);
    for (int i = 0; i < 2000 && n_done < 2; i++) begin @(negedge clk); #1; end
    por_done = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_two_done", n_done, 2);
    chk("b2b_nreads", addrs.size(), 2 * n);
    if (done_crcs.size() >= 2) begin
      chk("b2b_crc0", done_crcs[0], exp);
      chk("b2b_crc1", done_crcs[1], exp);
    end
    chk("b2b_idle", busy, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_crc", crc_calc, 0);
    chk("reset_done", init_done, 0);
    chk("reset_err", crc_err, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_case("pc0", 16'h0000, 0, 1'b0);
    chk("pc0_const", crc_calc, 16'hE2F0);
    spur = 1'b1;
    run_case("l6_zw", {5'd6, 11'($urandom)}, 0, 1'b0);
    run_case("l6_dly", 16'h3000 | 16'($urandom_range(2047, 0)), 5, 1'b0);
    run_case("clamp", {5'd31, 11'($urandom)}, 2, 1'b0);
    for (int k = 0; k < 4; k++) run_case("rand", 16'($urandom), 3, 1'b0);
    abort_case();
    reset_case();
    run_case("post_rst", 16'h0000, 0, 1'b0);
    chk("post_rst_const", crc_calc, 16'hE2F0);
    run_case("toggle", {5'd3, 11'($urandom)}, 2, 1'b1);
    b2b_case();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
